// File: rtl/ram_arbiter.sv
// Round-robin front end between the IFU and LSU and a combinational memory port.
// Inserts a fixed grant-to-access latency and registers read data for one strobe per access.
module ram_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        ram_ren,
    output logic [31:0] ram_raddr,
    input  logic [31:0] ram_rdata,
    output logic        ram_wen,
    output logic [31:0] ram_waddr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb
);
    typedef enum logic [1:0] {IDLE, BUSY, ACCESS, RESP} state_t;

    localparam logic       OWN_IFU    = 1'b0;
    localparam logic       OWN_LSU    = 1'b1;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        last_grant_reg, last_grant_next;
    logic [31:0] addr_reg, addr_next;
    logic        wen_reg, wen_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic [3:0]  count_reg, count_next;
    logic [31:0] data_reg, data_next;

    logic grant_ifu, grant_lsu;
    logic owner_resp_ready;
    logic in_access, in_resp;

    // Requests are only considered in IDLE; contention goes to whoever was not granted last.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (!reset && state_reg == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_ifu = (last_grant_reg == OWN_LSU);
                grant_lsu = (last_grant_reg == OWN_IFU);
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready    = grant_ifu;
    assign lsu_req_ready    = grant_lsu;
    assign owner_resp_ready = (owner_reg == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        wen_next        = wen_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        count_next      = count_reg;
        data_next       = data_reg;
        case (state_reg)
            IDLE: begin
                if (grant_ifu || grant_lsu) begin
                    owner_next      = grant_lsu;
                    last_grant_next = grant_lsu;
                    addr_next       = grant_lsu ? lsu_addr : ifu_addr;
                    wen_next        = grant_lsu & lsu_wen;
                    wdata_next      = grant_lsu ? lsu_wdata : 32'h0;
                    wstrb_next      = grant_lsu ? lsu_wstrb : 4'h0;
                    count_next      = COUNT_LOAD;
                    state_next      = (LATENCY > 1) ? BUSY : ACCESS;
                end
            end
            BUSY: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Writes report zero data; reads capture the memory's combinational result.
                data_next  = wen_reg ? 32'h0 : ram_rdata;
                state_next = RESP;
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_IFU;
            last_grant_reg <= OWN_LSU;
            addr_reg       <= 32'h0;
            wen_reg        <= 1'b0;
            wdata_reg      <= 32'h0;
            wstrb_reg      <= 4'h0;
            count_reg      <= 4'h0;
            data_reg       <= 32'h0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            wen_reg        <= wen_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            count_reg      <= count_next;
            data_reg       <= data_next;
        end
    end

    // Outputs are forced low during reset so a dropped transaction never leaks a strobe.
    assign in_access = !reset && (state_reg == ACCESS);
    assign in_resp   = !reset && (state_reg == RESP);

    assign ram_ren   = in_access && !wen_reg;
    assign ram_raddr = ram_ren ? addr_reg : 32'h0;
    assign ram_wen   = in_access && wen_reg && (wstrb_reg != 4'h0);
    assign ram_waddr = ram_wen ? addr_reg : 32'h0;
    assign ram_wdata = ram_wen ? wdata_reg : 32'h0;
    assign ram_wstrb = ram_wen ? wstrb_reg : 4'h0;

    assign ifu_resp_valid = in_resp && (owner_reg == OWN_IFU);
    assign lsu_resp_valid = in_resp && (owner_reg == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? data_reg : 32'h0;
    assign lsu_rdata      = lsu_resp_valid ? data_reg : 32'h0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three instances (LATENCY 1, 3, 4) driven by a vector table,
// hand-written reset/stall sequences and random transactions checked against a transaction model.
module tb_ram_arbiter;
    logic        clock;
    logic        reset          [3];
    logic        ifu_req_valid  [3];
    logic        ifu_req_ready  [3];
    logic [31:0] ifu_addr       [3];
    logic        ifu_resp_valid [3];
    logic        ifu_resp_ready [3];
    logic [31:0] ifu_rdata      [3];
    logic        lsu_req_valid  [3];
    logic        lsu_req_ready  [3];
    logic        lsu_wen        [3];
    logic [31:0] lsu_addr       [3];
    logic [31:0] lsu_wdata      [3];
    logic [3:0]  lsu_wstrb      [3];
    logic        lsu_resp_valid [3];
    logic        lsu_resp_ready [3];
    logic [31:0] lsu_rdata      [3];
    logic        ram_ren        [3];
    logic [31:0] ram_raddr      [3];
    logic [31:0] ram_rdata      [3];
    logic        ram_wen        [3];
    logic [31:0] ram_waddr      [3];
    logic [31:0] ram_wdata      [3];
    logic [3:0]  ram_wstrb      [3];

    logic [31:0] env_mem [3][2048];
    bit          env_wr  [3][2048];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          d;
        bit          iv;
        bit          lv;
        bit          who;
        bit          wen;
        logic [31:0] iaddr;
        logic [31:0] laddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hold;
        logic [31:0] exp_rdata;
    } vec_t;

    logic [31:0] ref_mem [longint];
    bit          ref_last [3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    // Power-up memory contents; the boot word sits at the reset vector.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_5A5A);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic longint ref_key(input int d, input logic [31:0] a);
        return (longint'(d) << 32) | longint'(a);
    endfunction

    function automatic logic [31:0] ref_read(input int d, input logic [31:0] a);
        longint k;
        k = ref_key(d, a);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(a);
    endfunction

    task automatic ref_write(input int d, input logic [31:0] a, input logic [31:0] w,
                             input logic [3:0] s);
        if (s != 4'h0) ref_mem[ref_key(d, a)] = merge(ref_read(d, a), w, s);
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            ram_arbiter #(.LATENCY(gi == 0 ? 1 : (gi == 1 ? 3 : 4))) u_dut (
                .clock          (clock),
                .reset          (reset[gi]),
                .ifu_req_valid  (ifu_req_valid[gi]),
                .ifu_req_ready  (ifu_req_ready[gi]),
                .ifu_addr       (ifu_addr[gi]),
                .ifu_resp_valid (ifu_resp_valid[gi]),
                .ifu_resp_ready (ifu_resp_ready[gi]),
                .ifu_rdata      (ifu_rdata[gi]),
                .lsu_req_valid  (lsu_req_valid[gi]),
                .lsu_req_ready  (lsu_req_ready[gi]),
                .lsu_wen        (lsu_wen[gi]),
                .lsu_addr       (lsu_addr[gi]),
                .lsu_wdata      (lsu_wdata[gi]),
                .lsu_wstrb      (lsu_wstrb[gi]),
                .lsu_resp_valid (lsu_resp_valid[gi]),
                .lsu_resp_ready (lsu_resp_ready[gi]),
                .lsu_rdata      (lsu_rdata[gi]),
                .ram_ren        (ram_ren[gi]),
                .ram_raddr      (ram_raddr[gi]),
                .ram_rdata      (ram_rdata[gi]),
                .ram_wen        (ram_wen[gi]),
                .ram_waddr      (ram_waddr[gi]),
                .ram_wdata      (ram_wdata[gi]),
                .ram_wstrb      (ram_wstrb[gi])
            );
            assign ram_rdata[gi] = !ram_ren[gi] ? 32'h0 :
                (env_wr[gi][ram_raddr[gi][12:2]] ? env_mem[gi][ram_raddr[gi][12:2]]
                                                 : init_word(ram_raddr[gi]));
        end
    endgenerate

    // Memory model behind each instance: byte-enabled writes on the clock edge.
    always @(posedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (ram_wen[d]) begin
                env_mem[d][ram_waddr[d][12:2]] <= merge(
                    env_wr[d][ram_waddr[d][12:2]] ? env_mem[d][ram_waddr[d][12:2]]
                                                  : init_word(ram_waddr[d]),
                    ram_wdata[d], ram_wstrb[d]);
                env_wr[d][ram_waddr[d][12:2]] <= 1'b1;
            end
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic chk_ram_idle(input int d, input string tag);
        chk1 ({tag, ".ram_ren"},   ram_ren[d],   1'b0);
        chk1 ({tag, ".ram_wen"},   ram_wen[d],   1'b0);
        chk32({tag, ".ram_raddr"}, ram_raddr[d], 32'h0);
        chk32({tag, ".ram_waddr"}, ram_waddr[d], 32'h0);
        chk32({tag, ".ram_wdata"}, ram_wdata[d], 32'h0);
        chk32({tag, ".ram_wstrb"}, 32'(ram_wstrb[d]), 32'h0);
    endtask

    task automatic chk_quiet(input int d, input string tag);
        chk1({tag, ".ifu_req_ready"},  ifu_req_ready[d],  1'b0);
        chk1({tag, ".lsu_req_ready"},  lsu_req_ready[d],  1'b0);
        chk1({tag, ".ifu_resp_valid"}, ifu_resp_valid[d], 1'b0);
        chk1({tag, ".lsu_resp_valid"}, lsu_resp_valid[d], 1'b0);
    endtask

    task automatic chk_all_zero(input int d, input string tag);
        chk_quiet(d, tag);
        chk_ram_idle(d, tag);
        chk32({tag, ".ifu_rdata"}, ifu_rdata[d], 32'h0);
        chk32({tag, ".lsu_rdata"}, lsu_rdata[d], 32'h0);
    endtask

    task automatic reset_dut(input int d);
        tick();
        reset[d] = 1'b1;
        ifu_req_valid[d] = 1'b1;
        lsu_req_valid[d] = 1'b1;
        sample();
        chk_all_zero(d, $sformatf("reset%0d", d));
        tick();
        reset[d] = 1'b0;
        ifu_req_valid[d] = 1'b0;
        lsu_req_valid[d] = 1'b0;
        sample();
        chk_all_zero(d, $sformatf("post_reset%0d", d));
        ref_last[d] = 1'b1;
    endtask

    // One transaction: wait for the grant, then check every cycle up to and including completion.
    task automatic run_txn(input vec_t v, input string tag);
        int          d   = v.d;
        int          lat = lat_of(v.d);
        bit          got = 1'b0;
        bit          wr  = v.who & v.wen;
        bit          wpulse;
        logic [31:0] a   = v.who ? v.laddr : v.iaddr;
        tick();
        ifu_resp_ready[d] = 1'b0;
        lsu_resp_ready[d] = 1'b0;
        ifu_req_valid[d]  = v.iv;
        ifu_addr[d]       = v.iaddr;
        lsu_req_valid[d]  = v.lv;
        lsu_wen[d]        = v.wen;
        lsu_addr[d]       = v.laddr;
        lsu_wdata[d]      = v.wdata;
        lsu_wstrb[d]      = v.wstrb;
        for (int i = 0; i < 20; i++) begin
            if (i != 0) tick();
            sample();
            if (ifu_req_ready[d] || lsu_req_ready[d]) begin
                got = 1'b1;
                break;
            end
        end
        chk1({tag, ".grant_within_budget"}, got, 1'b1);
        if (!got) begin
            ifu_req_valid[d] = 1'b0;
            lsu_req_valid[d] = 1'b0;
            return;
        end
        chk1({tag, ".ifu_req_ready"}, ifu_req_ready[d], !v.who);
        chk1({tag, ".lsu_req_ready"}, lsu_req_ready[d], v.who);
        chk_ram_idle(d, {tag, ".grant"});
        wpulse = wr && (v.wstrb != 4'h0);
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == 1) begin
                if (v.who) lsu_req_valid[d] = 1'b0;
                else       ifu_req_valid[d] = 1'b0;
            end
            sample();
            chk_quiet(d, $sformatf("%s.wait%0d", tag, k));
            if (k < lat) begin
                chk_ram_idle(d, $sformatf("%s.wait%0d", tag, k));
            end else begin
                chk1 ({tag, ".acc.ram_ren"},   ram_ren[d],   !wr);
                chk32({tag, ".acc.ram_raddr"}, ram_raddr[d], wr ? 32'h0 : a);
                chk1 ({tag, ".acc.ram_wen"},   ram_wen[d],   wpulse);
                chk32({tag, ".acc.ram_waddr"}, ram_waddr[d], wpulse ? a : 32'h0);
                chk32({tag, ".acc.ram_wdata"}, ram_wdata[d], wpulse ? v.wdata : 32'h0);
                chk32({tag, ".acc.ram_wstrb"}, 32'(ram_wstrb[d]), wpulse ? 32'(v.wstrb) : 32'h0);
            end
        end
        for (int h = 0; h <= v.hold; h++) begin
            tick();
            // The non-owner's resp_ready is held high to show it is ignored.
            if (v.who) begin
                lsu_resp_ready[d] = (h == v.hold);
                ifu_resp_ready[d] = 1'b1;
            end else begin
                ifu_resp_ready[d] = (h == v.hold);
                lsu_resp_ready[d] = 1'b1;
            end
            sample();
            chk1({tag, $sformatf(".resp%0d.ifu_resp_valid", h)}, ifu_resp_valid[d], !v.who);
            chk1({tag, $sformatf(".resp%0d.lsu_resp_valid", h)}, lsu_resp_valid[d], v.who);
            chk32({tag, $sformatf(".resp%0d.rdata", h)},
                  v.who ? lsu_rdata[d] : ifu_rdata[d], v.exp_rdata);
            chk1({tag, $sformatf(".resp%0d.ifu_req_ready", h)}, ifu_req_ready[d], 1'b0);
            chk1({tag, $sformatf(".resp%0d.lsu_req_ready", h)}, lsu_req_ready[d], 1'b0);
            chk_ram_idle(d, $sformatf("%s.resp%0d", tag, h));
        end
        ifu_req_valid[d] = 1'b0;
        lsu_req_valid[d] = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        run_txn(v, tag);
        ref_last[v.d] = v.who;
        if (v.who && v.wen) ref_write(v.d, v.laddr, v.wdata, v.wstrb);
        $display("txn %s dev=%0d who=%s wen=%0d addr=%h rdata_exp=%h", tag, v.d,
                 v.who ? "lsu" : "ifu", v.who & v.wen, v.who ? v.laddr : v.iaddr, v.exp_rdata);
    endtask

    function automatic vec_t mk(input int d, input bit iv, input bit lv, input bit who,
                                input bit wen, input logic [31:0] ia, input logic [31:0] la,
                                input logic [31:0] wd, input logic [3:0] ws, input int hold,
                                input logic [31:0] exp);
        vec_t v;
        v.d = d; v.iv = iv; v.lv = lv; v.who = who; v.wen = wen;
        v.iaddr = ia; v.laddr = la; v.wdata = wd; v.wstrb = ws; v.hold = hold;
        v.exp_rdata = exp;
        return v;
    endfunction

    vec_t tbl [10];

    initial begin
        vec_t v;
        for (int d = 0; d < 3; d++) begin
            reset[d] = 1'b1;
            ifu_req_valid[d] = 1'b0; ifu_addr[d] = 32'h0; ifu_resp_ready[d] = 1'b0;
            lsu_req_valid[d] = 1'b0; lsu_wen[d] = 1'b0; lsu_addr[d] = 32'h0;
            lsu_wdata[d] = 32'h0; lsu_wstrb[d] = 4'h0; lsu_resp_ready[d] = 1'b0;
            ref_last[d] = 1'b1;
        end

        //             d  iv lv who wen iaddr          laddr          wdata          ws   hold exp
        tbl[0] = mk(0, 1, 0, 0, 0, 32'h8000_0000, 32'h0,         32'h0,         4'h0, 0, 32'h0000_0413);
        tbl[1] = mk(1, 0, 1, 1, 1, 32'h0,         32'h8000_1000, 32'hDEAD_BEEF, 4'h3, 0, 32'h0);
        tbl[2] = mk(1, 0, 1, 1, 0, 32'h0,         32'h8000_1000, 32'h0,         4'h0, 0, 32'h25A5_BEEF);
        tbl[3] = mk(1, 0, 1, 1, 1, 32'h0,         32'h8000_0010, 32'h1234_5678, 4'h0, 0, 32'h0);
        tbl[4] = mk(1, 0, 1, 1, 0, 32'h0,         32'h8000_0010, 32'h0,         4'h0, 0, 32'h25A5_5A4A);
        tbl[5] = mk(1, 1, 0, 0, 0, 32'h8000_0000, 32'h0,         32'h0,         4'h0, 5, 32'h0000_0413);
        tbl[6] = mk(2, 1, 1, 0, 0, 32'h8000_0000, 32'h8000_0100, 32'h0,         4'h0, 0, 32'h0000_0413);
        tbl[7] = mk(2, 1, 1, 1, 0, 32'h8000_0004, 32'h8000_0100, 32'h0,         4'h0, 0, 32'h25A5_5B5A);
        tbl[8] = mk(2, 1, 1, 0, 0, 32'h8000_0004, 32'h8000_0100, 32'hCAFE_F00D, 4'hF, 0, 32'h25A5_5A5E);
        tbl[9] = mk(2, 1, 1, 1, 1, 32'h8000_0008, 32'h8000_0100, 32'hCAFE_F00D, 4'hF, 1, 32'h0);

        for (int d = 0; d < 3; d++) reset_dut(d);

        for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while the LATENCY=4 instance is counting down: nothing of that access may surface.
        tick();
        ifu_req_valid[2] = 1'b1;
        ifu_addr[2] = 32'h8000_0040;
        sample();
        chk1("rst_busy.grant", ifu_req_ready[2], 1'b1);
        tick();
        ifu_req_valid[2] = 1'b0;
        sample();
        chk_quiet(2, "rst_busy.busy");
        chk_ram_idle(2, "rst_busy.busy");
        tick();
        reset[2] = 1'b1;
        ifu_req_valid[2] = 1'b1;
        sample();
        chk_all_zero(2, "rst_busy.in_reset");
        tick();
        reset[2] = 1'b0;
        ifu_req_valid[2] = 1'b0;
        sample();
        chk_all_zero(2, "rst_busy.after");
        for (int c = 0; c < 6; c++) begin
            tick();
            sample();
            chk_quiet(2, $sformatf("rst_busy.idle%0d", c));
            chk_ram_idle(2, $sformatf("rst_busy.idle%0d", c));
        end
        $display("txn rst_busy dev=2 reset during BUSY, access dropped");
        ref_last[2] = 1'b1;
        apply(mk(2, 1, 1, 0, 0, 32'h8000_0040, 32'h8000_0100, 32'h0, 4'h0, 0,
                 ref_read(2, 32'h8000_0040)), "rst_busy.fresh");

        for (int i = 0; i < 40; i++) begin
            int r;
            v.d = $urandom_range(0, 2);
            r = $urandom_range(1, 3);
            v.iv = r[0];
            v.lv = r[1];
            v.who = (v.iv && v.lv) ? !ref_last[v.d] : v.lv;
            v.wen = $urandom_range(0, 1);
            v.iaddr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
            v.laddr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
            v.wdata = $urandom;
            v.wstrb = 4'($urandom_range(0, 15));
            v.hold = $urandom_range(0, 3);
            v.exp_rdata = (v.who && v.wen) ? 32'h0 : ref_read(v.d, v.who ? v.laddr : v.iaddr);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
